// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, debounce,
// edge pulses, toggle latch and optional auto-repeat press pulses per channel.
module btn_conditioner #(
    parameter int N            = 12,
    parameter int DEBOUNCE     = 500000,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1,
    parameter int CNT_W        = 20
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   btn_in,
    output logic [N-1:0]   btn_level,
    output logic [N-1:0]   btn_rise,
    output logic [N-1:0]   btn_fall,
    output logic [N-1:0]   btn_toggle,
    output logic [N-1:0]   btn_press,
    output logic [2*N-1:0] rep_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [CNT_W-1:0] dcnt [N];
    logic [N-1:0]     accept;
    logic [N-1:0]     acc_rise;
    logic [N-1:0]     acc_fall;
    logic [N-1:0]     level_next;
    logic [N-1:0]     rep_fire;

    // accept marks the edge on which the debounced level takes the new value
    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = (s2[i] != btn_level[i]) && (dcnt[i] == DB_LAST);
        end
        acc_rise   = accept & s2;
        acc_fall   = accept & ~s2;
        level_next = btn_level ^ accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            btn_level  <= '0;
            btn_rise   <= '0;
            btn_fall   <= '0;
            btn_toggle <= '0;
            btn_press  <= '0;
            for (int i = 0; i < N; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            s1         <= btn_in;
            s2         <= s1;
            btn_level  <= level_next;
            btn_rise   <= acc_rise;
            btn_fall   <= acc_fall;
            btn_toggle <= btn_toggle ^ acc_rise;
            btn_press  <= acc_rise | rep_fire;
            for (int i = 0; i < N; i++) begin
                if (s2[i] == btn_level[i] || accept[i]) begin
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    if (REPEAT_DELAY > 0) begin : g_rep
        localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

        for (genvar i = 0; i < N; i++) begin : g_ch
            rep_state_t       state;
            logic [CNT_W-1:0] rcnt;
            logic             fire;

            // Decisions use level_next so the btn_fall cycle itself never repeats.
            always_comb begin
                fire = 1'b0;
                case (state)
                    DELAY:   fire = level_next[i] && (rcnt == DELAY_LAST);
                    REPEAT:  fire = level_next[i] && (rcnt == RATE_LAST);
                    default: fire = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            rcnt <= '0;
                            if (acc_rise[i]) begin
                                state <= DELAY;
                            end
                        end
                        DELAY: begin
                            if (!level_next[i]) begin
                                state <= IDLE;
                                rcnt  <= '0;
                            end else if (rcnt == DELAY_LAST) begin
                                state <= REPEAT;
                                rcnt  <= '0;
                            end else begin
                                rcnt <= rcnt + CNT_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (!level_next[i]) begin
                                state <= IDLE;
                                rcnt  <= '0;
                            end else if (rcnt == RATE_LAST) begin
                                rcnt <= '0;
                            end else begin
                                rcnt <= rcnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end

            assign rep_fire[i]        = fire;
            assign rep_state[2*i +: 2] = state;
        end
    end else begin : g_no_rep
        assign rep_fire  = '0;
        assign rep_state = '0;
    end

endmodule
